// File: rtl/fetch_prefetch_queue_if.sv
// rtl/fetch_prefetch_queue_if.sv - memory read bus and CPU instruction handoff signals
interface fetch_prefetch_queue_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_address, mem_read, instr_valid, instr, instr_pc,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_address, mem_read, instr_valid, instr, instr_pc,
    output mem_waitrequest, mem_readdata, mem_readdatavalid, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch queue with redirect flush
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_queue_if.master  bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  typedef enum logic {ISSUE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          hold_drop_q, hold_drop_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          valid_q, valid_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q [DEPTH];

  logic          read, accept, stall, rvalid, push, pop, visible;
  logic [CW:0]   credit;
  logic [31:0]   new_pc;

  assign new_pc = bus.redirect_pc & ~32'h3;
  assign credit = {1'b0, count_q} + {1'b0, outstanding_q};
  // A stalled request must stay on the bus regardless of credit.
  assign read   = rst && ((state_q == HOLD) || (credit < DEPTH_C));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    hold_drop_d   = hold_drop_q;
    accept        = read && !bus.mem_waitrequest;
    stall         = read && bus.mem_waitrequest;
    rvalid        = bus.mem_readdatavalid;
    push          = rvalid && !bus.redirect && (discard_q == '0);
    pop           = valid_q && bus.instr_ready && !bus.redirect;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rvalid);

    if (stall) begin
      state_d = HOLD;
      if (bus.redirect) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = new_pc;
        hold_drop_d  = 1'b1;
      end
    end else begin
      state_d      = ISSUE;
      pend_valid_d = 1'b0;
      hold_drop_d  = 1'b0;
      if (bus.redirect)
        addr_d = new_pc;
      else if (accept)
        addr_d = pend_valid_q ? pend_pc_q : addr_q + 32'd4;
    end

    // Everything still in flight after a redirect belongs to the old stream.
    if (bus.redirect)
      discard_d = outstanding_d;
    else
      discard_d = discard_q - CW'(rvalid && (discard_q != '0)) + CW'(accept && hold_drop_q);

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
    visible    = (count_q - CW'(pop)) != '0;
    valid_d    = visible;
    instr_d    = visible ? fifo_instr_q[rd_ptr_d] : instr_q;
    instr_pc_d = visible ? fifo_pc_q[rd_ptr_d] : instr_pc_q;

    if (bus.redirect) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      resp_pc_d  = new_pc;
      valid_d    = 1'b0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ISSUE;
      addr_q        <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
      hold_drop_q   <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      resp_pc_q     <= RESET_PC;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      hold_drop_q   <= hold_drop_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      resp_pc_q     <= resp_pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.mem_readdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) assert ({1'b0, count_q} < DEPTH_C);
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_read    = read;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed vector bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if bus();
  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rdy;
    logic        rd;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t        vecs [8];
  int          passed = 0;
  int          total = 0;
  int          cyc, lat, stall_left, held_cycles, bad_data;
  int          mark_pop, mark_acc;
  logic [31:0] stall_addr;
  logic [31:0] resp_q[$];
  int          due_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  logic [31:0] pop_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_seq(input string name, input logic [31:0] q[$], input int start,
                           input logic [31:0] base, input int n);
    logic [31:0] want;
    total++;
    for (int i = 0; i < n; i++) begin
      want = base + 32'(4 * i);
      if (start + i >= q.size()) begin
        $display("FAIL %s: entry %0d missing, expected %0h", name, i, want);
        return;
      end
      if (q[start + i] !== want) begin
        $display("FAIL %s: entry %0d got %0h expected %0h", name, i, q[start + i], want);
        return;
      end
    end
    passed++;
  endtask

  // Memory agent plus monitor; inputs change 1 time unit after the falling edge.
  task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
    #1;
    cyc++;
    bus.instr_ready       = rdy;
    bus.redirect          = rd;
    bus.redirect_pc       = rpc;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata      = 32'h0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata      = memfn(resp_q[0]);
      void'(due_q.pop_front());
      void'(resp_q.pop_front());
    end
    bus.mem_waitrequest = 1'b0;
    if (bus.mem_read && bus.mem_address == stall_addr && stall_left > 0) begin
      bus.mem_waitrequest = 1'b1;
      stall_left--;
      held_cycles++;
    end
    if (bus.mem_read && !bus.mem_waitrequest) begin
      acc_q.push_back(bus.mem_address);
      acc_cyc_q.push_back(cyc);
      resp_q.push_back(bus.mem_address);
      due_q.push_back(cyc + lat);
    end
    if (bus.instr_valid && rdy && !rd) begin
      pop_q.push_back(bus.instr_pc);
      if (bus.instr !== memfn(bus.instr_pc)) bad_data++;
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    drive(rdy, 1'b0, 32'h0);
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) step(rdy);
  endtask

  task automatic restart(input int l, input logic rdy, input logic [31:0] saddr, input int scnt);
    rst = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_waitrequest   = 1'b0;
    bus.redirect          = 1'b0;
    @(negedge clk);
    resp_q.delete(); due_q.delete(); acc_q.delete(); acc_cyc_q.delete(); pop_q.delete();
    lat = l; cyc = -1; stall_addr = saddr; stall_left = scnt;
    held_cycles = 0; bad_data = 0;
    rst = 1'b1;
    drive(rdy, 1'b0, 32'h0);
  endtask

  initial begin
    bus.mem_waitrequest = 1'b0; bus.mem_readdata = 32'h0; bus.mem_readdatavalid = 1'b0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    stall_addr = 32'hFFFF_FFF0;
    #3;
    check("reset outputs", {bus.mem_read, bus.mem_address, bus.instr_valid, bus.instr, bus.instr_pc}, '0);

    // Zero-wait stream, 1-cycle latency: row i is the state after i clock edges.
    vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h0, memfn(32'h0)};
    vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h4, memfn(32'h4)};
    vecs[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h8, memfn(32'h8)};
    vecs[6] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'hC, memfn(32'hC)};
    vecs[7] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, memfn(32'h10)};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) restart(1, vecs[i].rdy, 32'hFFFF_FFF0, 0);
      else step(vecs[i].rdy);
      check($sformatf("stream row %0d", i),
            {bus.mem_read, bus.mem_address, bus.instr_valid, bus.instr_pc, bus.instr},
            {vecs[i].rd, vecs[i].addr, vecs[i].vld, vecs[i].pc, vecs[i].ins});
    end
    run(6, 1'b1);
    check_seq("stream pops", pop_q, 0, 32'h0, 10);
    check_seq("stream requests", acc_q, 0, 32'h0, 12);
    check("stream data", 128'(bad_data), 128'd0);

    // CPU stalled: credit stops fetch at DEPTH, then the queue drains in order.
    restart(1, 1'b0, 32'hFFFF_FFF0, 0);
    run(19, 1'b0);
    check("stall request count", 128'(acc_q.size()), 128'd4);
    check("stall held head", {bus.mem_read, bus.mem_address, bus.instr_valid, bus.instr_pc, bus.instr},
          {1'b0, 32'h10, 1'b1, 32'h0, memfn(32'h0)});
    run(12, 1'b1);
    check_seq("drain pops", pop_q, 0, 32'h0, 10);
    check_seq("drain requests", acc_q, 0, 32'h0, 12);
    check("drain data", 128'(bad_data), 128'd0);

    // Waitrequest on the request at 8 for three cycles.
    restart(1, 1'b1, 32'h8, 3);
    run(14, 1'b1);
    check("wait held cycles", 128'(held_cycles), 128'd3);
    check("wait accept cycle", 128'(acc_cyc_q[2]), 128'd5);
    check_seq("wait requests", acc_q, 0, 32'h0, 10);
    check_seq("wait pops", pop_q, 0, 32'h0, 8);
    check("wait data", 128'(bad_data), 128'd0);

    // Redirect with three reads in flight at 3-cycle latency.
    restart(3, 1'b1, 32'hFFFF_FFF0, 0);
    step(1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h100);
    check("redirect in flight", 128'(acc_q.size()), 128'd3);
    mark_pop = pop_q.size();
    run(20, 1'b1);
    check_seq("redirect pops", pop_q, mark_pop, 32'h100, 6);
    check_seq("redirect requests", acc_q, 3, 32'h100, 6);
    check("redirect data", 128'(bad_data), 128'd0);

    // Redirect while the request at 20 is held by waitrequest.
    restart(1, 1'b1, 32'h14, 3);
    run(5, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h203);
    mark_pop = pop_q.size();
    mark_acc = acc_q.size();
    run(14, 1'b1);
    check("hold redirect held cycles", 128'(held_cycles), 128'd3);
    check("hold redirect accept", {96'h0, acc_q[mark_acc]}, 128'h14);
    check("hold redirect accept cycle", 128'(acc_cyc_q[mark_acc]), 128'd8);
    check_seq("hold redirect requests", acc_q, mark_acc + 1, 32'h200, 5);
    check_seq("hold redirect pops", pop_q, mark_pop, 32'h200, 5);

    // Redirect near the top of the address space wraps to zero.
    restart(1, 1'b1, 32'hFFFF_FFF0, 0);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hFFFF_FFFB);
    mark_pop = pop_q.size();
    mark_acc = acc_q.size();
    run(12, 1'b1);
    check_seq("wrap requests", acc_q, mark_acc, 32'hFFFF_FFF8, 4);
    check_seq("wrap pops", pop_q, mark_pop, 32'hFFFF_FFF8, 5);

    // Asynchronous reset mid-stream, then a clean restart.
    restart(1, 1'b1, 32'hFFFF_FFF0, 0);
    run(6, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", {bus.mem_read, bus.mem_address, bus.instr_valid, bus.instr, bus.instr_pc}, '0);
    restart(1, 1'b1, 32'hFFFF_FFF0, 0);
    run(10, 1'b1);
    check_seq("post reset requests", acc_q, 0, 32'h0, 8);
    check_seq("post reset pops", pop_q, 0, 32'h0, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
